// File: rtl/db_event_arbiter.sv
// Debounce sample-strobe prescaler plus round-robin arbiter merging per-channel tick events onto one port.
// Latency: tick edge -> evt_valid after 2 edges when idle; at most one event every 2 cycles.
// Backpressure: evt_valid/evt_id hold until evt_ready; one pending slot per channel, extra ticks set overrun.
module db_event_arbiter #(
    parameter int N      = 4,
    parameter int PERIOD = 8,
    localparam int IW    = (N > 1) ? $clog2(N) : 1,
    localparam int CW    = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          sample_en,
    input  logic [N-1:0]  tick,
    output logic          evt_valid,
    output logic [IW-1:0] evt_id,
    input  logic          evt_ready,
    output logic [N-1:0]  pending,
    output logic [N-1:0]  overrun,
    input  logic [N-1:0]  ovr_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          sample_q;
    logic [IW-1:0] ptr;
    logic [IW-1:0] evt_id_q;
    logic [N-1:0]  pending_q, pending_nxt;
    logic [N-1:0]  overrun_q, overrun_nxt;
    logic          grant;
    logic [IW-1:0] grant_idx, hi_idx, any_idx;
    logic          hi_hit;
    logic [N-1:0]  grant_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            sample_q <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            if (enable) begin
                if (cnt == CW'(PERIOD - 1)) begin
                    cnt      <= '0;
                    sample_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Round-robin: prefer the lowest set channel at or above ptr, else wrap to the lowest set channel.
    always_comb begin
        hi_hit  = 1'b0;
        hi_idx  = '0;
        any_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                any_idx = IW'(i);
            end
            if (pending_q[i] && (IW'(i) >= ptr)) begin
                hi_hit = 1'b1;
                hi_idx = IW'(i);
            end
        end
        grant_idx = hi_hit ? hi_idx : any_idx;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (|pending_q) begin
                    grant     = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        grant_vec            = '0;
        grant_vec[grant_idx] = grant;
        // A tick on the granting edge refills the slot; a tick on an occupied, non-granted slot is dropped.
        pending_nxt = tick | (pending_q & ~grant_vec);
        overrun_nxt = (overrun_q & ~ovr_clr) | (tick & pending_q & ~grant_vec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            evt_id_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state     <= state_nxt;
            pending_q <= pending_nxt;
            overrun_q <= overrun_nxt;
            if (grant) begin
                evt_id_q <= grant_idx;
            end
            if ((state == OFFER) && evt_ready) begin
                ptr <= (evt_id_q == IW'(N - 1)) ? '0 : evt_id_q + 1'b1;
            end
        end
    end

    assign sample_en = sample_q;
    assign evt_valid = (state == OFFER);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_db_event_arbiter.sv
// Directed bench for db_event_arbiter: event-level reference model compared every cycle,
// plus literal expectations for strobe timing, grant order, stall stability and overrun handling.
module tb_db_event_arbiter;
    localparam int N      = 4;
    localparam int PERIOD = 8;

    logic         clk = 1'b0;
    logic         reset, enable, sample_en, evt_valid, evt_ready;
    logic [N-1:0] tick, pending, overrun, ovr_clr;
    logic [1:0]   evt_id;

    always #5 clk = ~clk;

    db_event_arbiter #(.N(N), .PERIOD(PERIOD)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sample_en (sample_en),
        .tick      (tick),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: state of the world in terms of events, updated on each rising edge.
    int  cyc        = 0;
    int  en_edges   = 0;
    bit  model_live = 1'b0;
    bit  m_sample, m_valid;
    int  m_id, m_ptr;
    bit  m_pend [N];
    bit  m_ovr  [N];
    int  t0 = 0;
    int  gq_id[$];
    int  gq_off[$];
    int  sq[$];
    bit  sq_on = 1'b0;

    function automatic logic [31:0] pack(input bit a [N]);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    always @(posedge clk) begin : model_upd
        int granted;
        bit old_p [N];
        if (reset) begin
            cyc = 0; en_edges = 0; m_sample = 0; m_valid = 0; m_id = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ovr[i] = 0; end
            model_live = 1'b1;
        end else begin
            cyc++;
            if (enable) begin
                en_edges++;
                m_sample = (en_edges % PERIOD == 0);
            end else begin
                m_sample = 0;
            end
            granted = -1;
            old_p   = m_pend;
            if (!m_valid) begin
                for (int k = 0; k < N; k++)
                    if (granted < 0 && old_p[(m_ptr + k) % N]) granted = (m_ptr + k) % N;
            end else if (evt_ready) begin
                m_valid = 0;
                m_ptr   = (m_id + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (ovr_clr[i]) m_ovr[i] = 0;
                if (tick[i]) begin
                    if (old_p[i] && granted != i) m_ovr[i] = 1;   // slot occupied: event lost
                    else m_pend[i] = 1;
                end else if (granted == i) begin
                    m_pend[i] = 0;
                end
            end
            if (granted >= 0) begin
                m_valid = 1;
                m_id    = granted;
                gq_id.push_back(granted);
                gq_off.push_back(cyc - t0);
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("sample_en", 32'(sample_en), 32'(m_sample));
            check("evt_valid", 32'(evt_valid), 32'(m_valid));
            check("evt_id",    32'(evt_id),    m_id);
            check("pending",   32'(pending),   pack(m_pend));
            check("overrun",   32'(overrun),   pack(m_ovr));
            if (sq_on && m_sample) sq.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grants(input string tag, input int n, input int ids[4], input int offs[4]);
        check($sformatf("%s_count", tag), gq_id.size(), n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_id%0d", tag, k),  (k < gq_id.size())  ? gq_id[k]  : -1, ids[k]);
            check($sformatf("%s_off%0d", tag, k), (k < gq_off.size()) ? gq_off[k] : -1, offs[k]);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; tick = '0; evt_ready = 1'b0; ovr_clr = '0;
        repeat (3) step();
        check("rst_sample_en", 32'(sample_en), 0);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_evt_id",    32'(evt_id),    0);
        check("rst_pending",   32'(pending),   0);
        check("rst_overrun",   32'(overrun),   0);

        // Free-running prescaler, no traffic
        reset = 1'b0; enable = 1'b1; sq_on = 1'b1;
        repeat (26) step();
        sq_on = 1'b0;
        check("strobe_count", sq.size(), 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("strobe_cyc%0d", k), (k < sq.size()) ? sq[k] : -1, 8 * (k + 1));

        // Prescaler freeze and resume
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        repeat (10) step();

        // Two channels, consumer always ready
        evt_ready = 1'b1; gq_id.delete(); gq_off.delete(); t0 = cyc;
        tick = 4'b0101; step(); tick = '0;
        repeat (6) step();
        check_grants("pair", 2, '{0, 2, 0, 0}, '{2, 4, 0, 0});
        check("pair_pending_drained", 32'(pending), 0);

        // All channels: rotation continues from channel 3
        gq_id.delete(); gq_off.delete(); t0 = cyc;
        tick = 4'b1111; step(); tick = '0;
        repeat (10) step();
        check_grants("all", 4, '{3, 0, 1, 2}, '{2, 4, 6, 8});

        // Stalled consumer with repeated ticks on channel 1
        evt_ready = 1'b0; gq_id.delete(); gq_off.delete(); t0 = cyc;
        tick = 4'b0010; step(); tick = '0; step();
        check_grants("stall", 1, '{1, 0, 0, 0}, '{2, 0, 0, 0});
        for (int w = 0; w < 10; w++) begin
            tick = (w == 2 || w == 6) ? 4'b0010 : 4'b0000;
            step();
            check($sformatf("stall_valid%0d", w), 32'(evt_valid), 1);
            check($sformatf("stall_id%0d", w),    32'(evt_id),    1);
            if (w >= 2) check($sformatf("stall_pend%0d", w), 32'(pending[1]), 1);
            check($sformatf("stall_ovr%0d", w), 32'(overrun), (w >= 6) ? 32'h2 : 32'h0);
        end
        tick = '0;

        // Overrun clear, then clear colliding with a new overflow
        ovr_clr = 4'b0010; step(); ovr_clr = '0;
        check("ovr_clear", 32'(overrun), 0);
        tick = 4'b0010; ovr_clr = 4'b0010; step();
        check("ovr_set_wins", 32'(overrun), 32'h2);
        tick = '0; step(); ovr_clr = '0;
        check("ovr_clear2", 32'(overrun), 0);

        // Drain channel 1 twice
        evt_ready = 1'b1; gq_id.delete(); gq_off.delete(); t0 = cyc;
        repeat (3) step();
        check_grants("drain", 1, '{1, 0, 0, 0}, '{2, 0, 0, 0});

        // Build OFFER with pending 1010, then reset
        evt_ready = 1'b0;
        tick = 4'b1010; step();
        tick = 4'b0000; step();
        tick = 4'b1000; step();
        tick = '0;
        check("pre_rst_valid",   32'(evt_valid), 1);
        check("pre_rst_id",      32'(evt_id),    3);
        check("pre_rst_pending", 32'(pending),   32'ha);
        reset = 1'b1; evt_ready = 1'b1; tick = 4'b1111; step();
        check("mid_rst_valid",   32'(evt_valid), 0);
        check("mid_rst_id",      32'(evt_id),    0);
        check("mid_rst_pending", 32'(pending),   0);
        check("mid_rst_overrun", 32'(overrun),   0);
        check("mid_rst_sample",  32'(sample_en), 0);
        reset = 1'b0; tick = '0; evt_ready = 1'b0;
        gq_id.delete(); gq_off.delete(); t0 = cyc;
        tick = 4'b1000; step(); tick = '0; step();
        check_grants("post_rst", 1, '{3, 0, 0, 0}, '{2, 0, 0, 0});
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
